kernel_pr_write_back: RTL

- PageRank write-back stage; sits directly downstream of the write_back start FIFO.
- Pops one start token per run, then drains a stream of updated rank words.
- Packs the words into bursts of up to BURST_LEN beats and writes them to memory over an AXI-style AW/W/B master.
- Pulses done when all num_vertices words are acknowledged.

---
 rtl/kernel_pr_write_back.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/kernel_pr_write_back.sv
// kernel_pr_write_back: PageRank write-back stage.
// Takes one token from the start FIFO per run, then reads updated rank words
// from the rank FIFO. It groups them into bursts of up to BURST_LEN beats and
// writes each burst through an AW/W/B write master. Only one burst is in
// flight at any time. done pulses once when the final burst is acknowledged.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start_empty_n/start_read   start token FIFO handshake (start_read is comb)
//   num_vertices, base_addr    run length in words / byte base, sampled at pop
//   rank_empty_n/rank_dout     rank FIFO status and head word
//   rank_read                  rank FIFO pop (comb)
//   m_aw*                      write address channel (registered)
//   m_w*                       write data channel (registered)
//   m_bvalid/m_bready          write response channel (response code ignored)
//   done                       one-cycle completion pulse
//   busy                       high whenever the FSM is not idle
module kernel_pr_write_back #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic [CNT_WIDTH-1:0]  num_vertices,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  rank_empty_n,
  input  logic [DATA_WIDTH-1:0] rank_dout,
  output logic                  rank_read,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wlast,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int unsigned IDX_W          = $clog2(BURST_LEN);
  localparam int unsigned TGT_W          = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   remaining_q;
  logic [CNT_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [TGT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       beat_q;
  logic [DATA_WIDTH-1:0]  rank_buf [BURST_LEN];

  logic [TGT_W-1:0]       target_c;
  logic [TGT_W-1:0]       cnt_inc_c;
  logic [TGT_W-1:0]       beat_inc_c;
  logic [ADDR_WIDTH-1:0]  burst_addr_c;
  logic                   start_pop_c;
  logic                   rank_pop_c;

  // Beats in the current burst: a full burst, or whatever is left over.
  always_comb begin
    target_c = TGT_W'(remaining_q);
    if (remaining_q >= CNT_WIDTH'(BURST_LEN)) begin
      target_c = TGT_W'(BURST_LEN);
    end
  end

  assign cnt_inc_c    = cnt_q + TGT_W'(1);
  assign beat_inc_c   = TGT_W'(beat_q) + TGT_W'(1);
  // Byte address of the burst; overflow simply wraps.
  assign burst_addr_c = base_q + ADDR_WIDTH'(ptr_q) * ADDR_WIDTH'(BYTES_PER_WORD);

  // FIFO pops are combinational so a word can be taken every cycle in FILL.
  assign start_pop_c = ~reset & (state_q == S_IDLE) & start_empty_n;
  assign rank_pop_c  = ~reset & (state_q == S_FILL) & rank_empty_n & (cnt_q < target_c);
  assign start_read  = start_pop_c;
  assign rank_read   = rank_pop_c;

  // Burst staging buffer; contents are don't-care outside a fill.
  always_ff @(posedge clk) begin
    if (rank_pop_c) begin
      rank_buf[cnt_q[IDX_W-1:0]] <= rank_dout;
    end
  end

  // Control FSM with registered channel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      ptr_q       <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      m_awvalid   <= 1'b0;
      m_awaddr    <= '0;
      m_awlen     <= '0;
      m_wvalid    <= 1'b0;
      m_wdata     <= '0;
      m_wlast     <= 1'b0;
      m_bready    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_pop_c) begin
            remaining_q <= num_vertices;
            base_q      <= base_addr;
            ptr_q       <= '0;
            cnt_q       <= '0;
            busy        <= 1'b1;
            if (num_vertices == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_FILL;
            end
          end
        end

        S_FILL: begin
          if (rank_pop_c) begin
            cnt_q <= cnt_inc_c;
            // Leave as soon as the last word of the burst is captured.
            if (cnt_inc_c == target_c) begin
              state_q   <= S_AW;
              m_awvalid <= 1'b1;
              m_awaddr  <= burst_addr_c;
              m_awlen   <= 8'(target_c - TGT_W'(1));
            end
          end
        end

        S_AW: begin
          if (m_awready) begin
            state_q   <= S_W;
            m_awvalid <= 1'b0;
            beat_q    <= '0;
            m_wvalid  <= 1'b1;
            m_wdata   <= rank_buf[0];
            m_wlast   <= (target_c == TGT_W'(1));
          end
        end

        S_W: begin
          if (m_wready) begin
            if (m_wlast) begin
              state_q  <= S_B;
              m_wvalid <= 1'b0;
              m_wlast  <= 1'b0;
              m_bready <= 1'b1;
            end else begin
              beat_q  <= beat_inc_c[IDX_W-1:0];
              m_wdata <= rank_buf[beat_inc_c[IDX_W-1:0]];
              m_wlast <= (beat_inc_c == target_c - TGT_W'(1));
            end
          end
        end

        S_B: begin
          if (m_bvalid) begin
            m_bready    <= 1'b0;
            ptr_q       <= ptr_q + CNT_WIDTH'(target_c);
            remaining_q <= remaining_q - CNT_WIDTH'(target_c);
            cnt_q       <= '0;
            if (remaining_q == CNT_WIDTH'(target_c)) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_q <= S_FILL;
            end
          end
        end

        S_DONE: begin
          // A burst run arrives here with done already set. A zero-length run
          // arrives with done clear and raises it one cycle later.
          if (done) begin
            done    <= 1'b0;
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
